bcd2bin_serial: RTL and testbench
=================================

# bcd2bin_serial

Serial BCD-to-binary converter using reverse double dabble (shift right, subtract 3). It is the inverse of the score-path binary-to-BCD converter. It converts BCD values held in decimal form into binary: stored high scores, digit-entry settings, and level and line targets. One conversion runs at a time under a start/busy/done handshake, with 4*BCD_DIGITS shift cycles per conversion.

## Interface
- BCD_DIGITS, 5: number of BCD input digits.
- BINARY_BITS, 17: width of the binary output. 17 holds 99999.
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  request a conversion. Accepted only in IDLE.
- bcd_in  input  4*BCD_DIGITS  BCD operand, digit 0 in bits [3:0]. Sampled on the accepting edge only.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse: bin_out, err and ovf are updated.
- bin_out  output  BINARY_BITS  binary result. Held until the next done.
- err  output  1  the last conversion had a digit > 9.
- ovf  output  1  the last result did not fit in BINARY_BITS.

## Operation
- Internal state:
  - FSM states IDLE and SHIFT.
  - BCD work register, 4*BCD_DIGITS bits.
  - Binary accumulator, 4*BCD_DIGITS bits.
  - Step counter, $clog2(4*BCD_DIGITS)+1 bits.
  - Sticky invalid flag.
- IDLE with start=1, on the accepting edge:
  - Load the work register from bcd_in and clear the accumulator.
  - Set the counter to 4*BCD_DIGITS.
  - Set the invalid flag if any digit of bcd_in is greater than 9.
  - Go to SHIFT.
- SHIFT, one step per edge:
  - Shift {work, accumulator} right by 1; work bit 0 enters accumulator MSB.
  - In the same step, after the shift, subtract 3 from every work digit that is ≥ 8.
  - Decrement the counter.
- Last step (counter 1→0):
  - With the invalid flag set: bin_out=0, err=1, ovf=0.
  - Otherwise: bin_out = accumulator[BINARY_BITS-1:0], err=0, ovf=1 if any accumulator bit at or above BINARY_BITS is set.
  - done pulses; go to IDLE.
- The correction is per digit and 4-bit modulo. Invalid digits still run the full step count, but their arithmetic result is discarded.
- No output changes except at reset or at the last step.
- If BINARY_BITS ≥ 4*BCD_DIGITS, ovf is constant 0 and the upper bits of bin_out are zero-extended.

## Timing
- Reset values:
  - busy=0, done=0, err=0, ovf=0, bin_out=0.
  - FSM in IDLE, counter=0, work register and accumulator=0.
- Reset mid-conversion aborts it. No done is produced and the outputs take their reset values on that edge.
- Handshake, with start accepted at edge k:
  - busy=1 from edge k through edge k+4*BCD_DIGITS, exclusive.
  - At edge k+4*BCD_DIGITS: busy falls and done rises with new bin_out, err and ovf.
  - done falls at edge k+4*BCD_DIGITS+1.
- Latency: 4*BCD_DIGITS cycles from the accepting edge to done. That is 20 cycles at the default.
- start while busy=1 is ignored, not queued. bcd_in changes during busy have no effect.
- start during the done cycle is accepted (FSM is IDLE). busy=1 and done=1 never occur together.
- start held high continuously runs back-to-back conversions, one every 4*BCD_DIGITS+1 cycles.

## Test plan
- Reset, then bcd_in=0x12345 with start pulse -> done exactly 20 cycles later; bin_out=0x03039 (12345), err=0, ovf=0; busy high for cycles 1–19 after acceptance.
- bcd_in=0x99999 -> bin_out=0x1869F; bcd_in=0x00000 -> bin_out=0; bcd_in=0x00009 -> bin_out=9; all with err=0.
- bcd_in=0x1A345 (digit 3 = 0xA) -> err=1, bin_out=0, ovf=0; the next valid conversion of 0x00042 clears err, bin_out=42.
- BINARY_BITS=16 build:
  - 0x65535 -> bin_out=0xFFFF, ovf=0.
  - 0x65536 -> bin_out=0x0000, ovf=1.
- Start pulses at cycles 5 and 12 after acceptance of 0x00100, with bcd_in changed to 0x00777 -> ignored; a single done with bin_out=100. start held high -> done every 21 cycles.
- rst asserted 10 cycles into a conversion of 0x54321 -> no done; all outputs 0, busy=0 next cycle; a fresh start converts 0x54321 -> 0x0D431.

Source files
------------

// File: rtl/bcd2bin_serial_if.sv
// bcd2bin_serial_if: start/busy/done handshake and data bundle for the serial BCD-to-binary converter.
interface bcd2bin_serial_if #(
  parameter int BCD_DIGITS  = 5,
  parameter int BINARY_BITS = 17
);
  logic                    start;
  logic [4*BCD_DIGITS-1:0] bcd_in;
  logic                    busy;
  logic                    done;
  logic [BINARY_BITS-1:0]  bin_out;
  logic                    err;
  logic                    ovf;
  modport master (output start, bcd_in, input busy, done, bin_out, err, ovf);
  modport slave  (input start, bcd_in, output busy, done, bin_out, err, ovf);
endinterface

// File: rtl/bcd2bin_serial.sv
// bcd2bin_serial: serial BCD-to-binary converter, reverse double dabble (shift right, subtract 3).
module bcd2bin_serial #(
  parameter int BCD_DIGITS  = 5,
  parameter int BINARY_BITS = 17
) (
  input logic             clk,
  input logic             rst,
  bcd2bin_serial_if.slave bus
);
  localparam int W  = 4 * BCD_DIGITS;
  localparam int CW = $clog2(W) + 1;
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;
  logic [0:0]             r_state;
  logic [W-1:0]           r_work;
  logic [W-1:0]           r_acc;
  logic [CW-1:0]          r_cnt;
  logic                   r_inv;
  logic [W-1:0]           w_work_sh;
  logic [W-1:0]           w_work_nx;
  logic [W-1:0]           w_acc_nx;
  logic                   w_bad;
  logic [BINARY_BITS-1:0] w_bin;
  logic                   w_ovf;
  assign {w_work_sh, w_acc_nx} = {r_work, r_acc} >> 1;
  always_comb begin
    w_work_nx = w_work_sh;
    w_bad     = 1'b0;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      w_work_nx[4*i+:4] = (w_work_sh[4*i+:4] >= 4'd8) ? w_work_sh[4*i+:4] - 4'd3 : w_work_sh[4*i+:4];
      w_bad = w_bad | (bus.bcd_in[4*i+:4] > 4'd9);
    end
  end
  // The result is taken from the post-shift accumulator of the final step.
  generate
    if (BINARY_BITS >= W) begin : g_wide
      assign w_bin = BINARY_BITS'(w_acc_nx);
      assign w_ovf = 1'b0;
    end else begin : g_narrow
      assign w_bin = w_acc_nx[BINARY_BITS-1:0];
      assign w_ovf = |w_acc_nx[W-1:BINARY_BITS];
    end
  endgenerate
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_work      <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_inv       <= 1'b0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.bin_out <= '0;
      bus.err     <= 1'b0;
      bus.ovf     <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      if (r_state == IDLE) begin
        if (bus.start) begin
          r_work   <= bus.bcd_in;
          r_acc    <= '0;
          r_cnt    <= CW'(W);
          r_inv    <= w_bad;
          r_state  <= SHIFT;
          bus.busy <= 1'b1;
        end
      end else begin
        r_work <= w_work_nx;
        r_acc  <= w_acc_nx;
        r_cnt  <= r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          r_state     <= IDLE;
          bus.busy    <= 1'b0;
          bus.done    <= 1'b1;
          bus.bin_out <= r_inv ? '0 : w_bin;
          bus.err     <= r_inv;
          bus.ovf     <= !r_inv && w_ovf;
        end
      end
    end
  end
endmodule

// File: tb/tb_bcd2bin_serial.sv
// tb_bcd2bin_serial: directed scoreboard bench for bcd2bin_serial (17-bit and 16-bit output builds).
module tb_bcd2bin_serial;
  typedef struct packed {
    logic [16:0] bin;
    logic        err;
    logic        ovf;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   n;
  exp_t q17[$];
  exp_t q16[$];
  exp_t e17, e16;
  always #5 clk = ~clk;
  bcd2bin_serial_if #(.BCD_DIGITS(5), .BINARY_BITS(17)) u_if();
  bcd2bin_serial_if #(.BCD_DIGITS(5), .BINARY_BITS(16)) u_if16();
  bcd2bin_serial #(.BCD_DIGITS(5), .BINARY_BITS(17)) dut   (.clk(clk), .rst(rst), .bus(u_if));
  bcd2bin_serial #(.BCD_DIGITS(5), .BINARY_BITS(16)) dut16 (.clk(clk), .rst(rst), .bus(u_if16));

  function automatic exp_t model(logic [19:0] bcd, int b);
    exp_t e;
    int v;
    logic bad;
    logic [3:0] d;
    v = 0;
    bad = 1'b0;
    for (int i = 4; i >= 0; i--) begin
      d = bcd[4*i+:4];
      bad = bad | (d > 4'd9);
      v = v * 10 + int'(d);
    end
    e.err = bad;
    e.ovf = !bad && (v >= (1 << b));
    e.bin = bad ? 17'd0 : 17'(v % (1 << b));
    return e;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go(bit w16, logic [19:0] bcd, bit track);
    if (w16) begin
      u_if16.bcd_in = bcd;
      u_if16.start = 1'b1;
      if (track) q16.push_back(model(bcd, 16));
    end else begin
      u_if.bcd_in = bcd;
      u_if.start = 1'b1;
      if (track) q17.push_back(model(bcd, 17));
    end
    step();
    u_if.start = 1'b0;
    u_if16.start = 1'b0;
  endtask

  task automatic wait_done(bit w16);
    int k;
    k = 0;
    while ((w16 ? u_if16.done : u_if.done) !== 1'b1 && k < 60) begin
      step();
      k++;
    end
    chk(w16 ? "done_timeout16" : "done_timeout17", k < 60, 1);
  endtask

  always @(negedge clk) begin
    if (u_if.done === 1'b1) begin
      chk("m17_expected", q17.size() > 0, 1);
      chk("m17_busy_with_done", u_if.busy, 0);
      if (q17.size() > 0) begin
        e17 = q17.pop_front();
        chk("m17_bin", u_if.bin_out, e17.bin);
        chk("m17_err", u_if.err, e17.err);
        chk("m17_ovf", u_if.ovf, e17.ovf);
      end
    end
  end

  always @(negedge clk) begin
    if (u_if16.done === 1'b1) begin
      chk("m16_expected", q16.size() > 0, 1);
      if (q16.size() > 0) begin
        e16 = q16.pop_front();
        chk("m16_bin", u_if16.bin_out, e16.bin);
        chk("m16_err", u_if16.err, e16.err);
        chk("m16_ovf", u_if16.ovf, e16.ovf);
      end
    end
  end

  initial begin
    u_if.start = 1'b0;
    u_if.bcd_in = '0;
    u_if16.start = 1'b0;
    u_if16.bcd_in = '0;
    repeat (3) step();
    rst = 1'b0;
    chk("rst_busy", u_if.busy, 0);
    chk("rst_done", u_if.done, 0);
    chk("rst_bin", u_if.bin_out, 0);
    chk("rst_err", u_if.err, 0);
    chk("rst_ovf", u_if.ovf, 0);
    chk("rst_bin16", u_if16.bin_out, 0);
    // Cycle-exact handshake: busy after edges k..k+19, done at edge k+20.
    go(0, 20'h12345, 1);
    for (int i = 0; i < 20; i++) begin
      chk("run_busy", u_if.busy, 1);
      chk("run_no_done", u_if.done, 0);
      step();
    end
    chk("lat_done", u_if.done, 1);
    chk("lat_busy", u_if.busy, 0);
    chk("lat_bin", u_if.bin_out, 17'h03039);
    go(0, 20'h99999, 1);
    wait_done(0);
    go(0, 20'h00000, 1);
    wait_done(0);
    go(0, 20'h00009, 1);
    wait_done(0);
    go(0, 20'h1A345, 1);
    wait_done(0);
    go(0, 20'h00042, 1);
    wait_done(0);
    // Starts while busy, with a different operand, must be ignored.
    go(0, 20'h00100, 1);
    repeat (4) step();
    u_if.bcd_in = 20'h00777;
    u_if.start = 1'b1;
    step();
    u_if.start = 1'b0;
    repeat (6) step();
    u_if.start = 1'b1;
    step();
    u_if.start = 1'b0;
    wait_done(0);
    repeat (25) step();
    // Held start: back-to-back conversions every 21 cycles.
    q17.push_back(model(20'h00321, 17));
    q17.push_back(model(20'h00321, 17));
    u_if.bcd_in = 20'h00321;
    u_if.start = 1'b1;
    step();
    n = 0;
    while (u_if.done !== 1'b1 && n < 60) begin
      step();
      n++;
    end
    chk("held_first_latency", n, 20);
    n = 0;
    do begin
      step();
      n++;
    end while (u_if.done !== 1'b1 && n < 60);
    chk("held_period", n, 21);
    u_if.start = 1'b0;
    step();
    // Reset ten edges into a conversion aborts it with no done.
    go(0, 20'h54321, 0);
    repeat (9) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy", u_if.busy, 0);
    chk("abort_done", u_if.done, 0);
    chk("abort_bin", u_if.bin_out, 0);
    chk("abort_err", u_if.err, 0);
    chk("abort_ovf", u_if.ovf, 0);
    repeat (25) step();
    go(0, 20'h54321, 1);
    wait_done(0);
    chk("fresh_bin", u_if.bin_out, 17'h0D431);
    // Narrow build: 65535 fits, 65536 overflows.
    go(1, 20'h65535, 1);
    wait_done(1);
    go(1, 20'h65536, 1);
    wait_done(1);
    go(1, 20'h1A345, 1);
    wait_done(1);
    repeat (5) step();
    chk("q17_drained", q17.size(), 0);
    chk("q16_drained", q16.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
